rhythm_judge_core: RTL

- Parametrised N-track game-flow and judgement core for the rhythm game.
- Owns the game state FSM (IDLE/PLAY/RESULT) with abort and restart. The current top only latches a start flag and never clears it.
- Classifies button presses against per-track note zones, issues note-clear requests, and maintains score, combo and max combo.
- Sits between button_ctrl / the LCD note-window logic and the score, LED and segment displays. Replaces the fixed two-track judgement path and the ad-hoc start register.

---
 rtl/rhythm_pkg.sv | 11 +
 rtl/rhythm_judge_core_if.sv | 23 ++
 rtl/track_judge.sv | 16 +
 rtl/rhythm_judge_core.sv | 96 +++++++++
 4 files changed

// File: rtl/rhythm_pkg.sv
// rhythm_pkg: judge/state codes and saturating add shared by the rhythm judge core
package rhythm_pkg;
  typedef enum logic [1:0] {J_NONE = 2'd0, J_MISS = 2'd1, J_GOOD = 2'd2, J_PERFECT = 2'd3} judge_t;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_RESULT = 2'd2} state_t;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [32:0] s, m;
    s = {1'b0, a} + {1'b0, b};
    m = (33'd1 << w) - 33'd1;
    return s > m ? m[31:0] : s[31:0];
  endfunction
endpackage

// File: rtl/rhythm_judge_core_if.sv
// rhythm_judge_core_if: game-control, track event and judgement/score signals of the judge core
interface rhythm_judge_core_if #(
  parameter int N_TRACKS = 4,
  parameter int SCORE_W  = 16,
  parameter int COMBO_W  = 10
);
  logic                i_tick, i_start, i_restart, i_song_end;
  logic [N_TRACKS-1:0] i_btn, i_zone_perf, i_zone_good, i_miss;
  logic [1:0]          o_state;
  logic                o_run;
  logic [N_TRACKS-1:0] o_clr_perf, o_clr_good;
  logic [1:0]          o_judge, o_judge_hold;
  logic [SCORE_W-1:0]  o_score;
  logic [COMBO_W-1:0]  o_combo, o_max_combo;
  modport master (
    output i_tick, i_start, i_restart, i_song_end, i_btn, i_zone_perf, i_zone_good, i_miss,
    input  o_state, o_run, o_clr_perf, o_clr_good, o_judge, o_judge_hold, o_score, o_combo, o_max_combo
  );
  modport slave (
    input  i_tick, i_start, i_restart, i_song_end, i_btn, i_zone_perf, i_zone_good, i_miss,
    output o_state, o_run, o_clr_perf, o_clr_good, o_judge, o_judge_hold, o_score, o_combo, o_max_combo
  );
endinterface

// File: rtl/track_judge.sv
// track_judge: combinational per-track classification of a press or miss against the note zones
module track_judge
  import rhythm_pkg::*;
(
  input  logic   btn,
  input  logic   zone_perf,
  input  logic   zone_good,
  input  logic   miss,
  output judge_t judge,
  output logic   clr_perf,
  output logic   clr_good
);
  assign clr_perf = btn & zone_perf;
  assign clr_good = btn & ~zone_perf & zone_good;
  assign judge = clr_perf ? J_PERFECT : clr_good ? J_GOOD : miss ? J_MISS : J_NONE;
endmodule

// File: rtl/rhythm_judge_core.sv
// rhythm_judge_core: game-flow FSM plus N-track judgement, score, combo and judge-hold registers
module rhythm_judge_core
  import rhythm_pkg::*;
#(
  parameter int N_TRACKS   = 4,
  parameter int SCORE_W    = 16,
  parameter int COMBO_W    = 10,
  parameter int PERF_PTS   = 3,
  parameter int GOOD_PTS   = 1,
  parameter int HOLD_TICKS = 500
) (
  input logic clk,
  input logic rst,
  rhythm_judge_core_if.slave bus
);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int CW = $clog2(N_TRACKS + 1);
  judge_t              jd [N_TRACKS];
  logic [N_TRACKS-1:0] cp, cg;
  state_t              state;
  logic [HW-1:0]       hcnt;
  logic                active, any_miss;
  logic [CW-1:0]       n_perf, n_good;
  judge_t              worst;
  logic [31:0]         pts, gain, new_combo;
  for (genvar g = 0; g < N_TRACKS; g++) begin : g_trk
    track_judge u_tj (
      .btn(bus.i_btn[g]), .zone_perf(bus.i_zone_perf[g]), .zone_good(bus.i_zone_good[g]),
      .miss(bus.i_miss[g]), .judge(jd[g]), .clr_perf(cp[g]), .clr_good(cg[g])
    );
  end
  // events in the cycle that leaves PLAY are dropped, so nothing is judged outside PLAY
  assign active = state == S_PLAY && !bus.i_restart && !bus.i_song_end;
  assign bus.o_state = state;
  always_comb begin
    n_perf = '0;
    n_good = '0;
    any_miss = 1'b0;
    for (int k = 0; k < N_TRACKS; k++) begin
      n_perf = n_perf + CW'(jd[k] == J_PERFECT);
      n_good = n_good + CW'(jd[k] == J_GOOD);
      any_miss = any_miss | (jd[k] == J_MISS);
    end
    worst = any_miss ? J_MISS : n_good != '0 ? J_GOOD : n_perf != '0 ? J_PERFECT : J_NONE;
    gain = 32'(n_perf) + 32'(n_good);
    pts = 32'(PERF_PTS) * 32'(n_perf) + 32'(GOOD_PTS) * 32'(n_good);
    new_combo = sat_add(any_miss ? 32'd0 : 32'(bus.o_combo), gain, COMBO_W);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      hcnt             <= '0;
      bus.o_run        <= 1'b0;
      bus.o_clr_perf   <= '0;
      bus.o_clr_good   <= '0;
      bus.o_judge      <= J_NONE;
      bus.o_judge_hold <= J_NONE;
      bus.o_score      <= '0;
      bus.o_combo      <= '0;
      bus.o_max_combo  <= '0;
    end else begin
      bus.o_judge    <= active ? worst : J_NONE;
      bus.o_clr_perf <= active ? cp : '0;
      bus.o_clr_good <= active ? cg : '0;
      if (active) begin
        bus.o_score <= SCORE_W'(sat_add(32'(bus.o_score), pts, SCORE_W));
        bus.o_combo <= COMBO_W'(new_combo);
        if (new_combo > 32'(bus.o_max_combo)) bus.o_max_combo <= COMBO_W'(new_combo);
      end
      if (active && worst != J_NONE) begin
        bus.o_judge_hold <= worst;
        hcnt             <= HW'(HOLD_TICKS);
      end else if (bus.i_tick && hcnt != '0) begin
        hcnt <= hcnt - HW'(1);
        if (hcnt == HW'(1)) bus.o_judge_hold <= J_NONE;
      end
      case (state)
        S_IDLE: if (bus.i_start) begin
          state           <= S_PLAY;
          bus.o_run       <= 1'b1;
          bus.o_score     <= '0;
          bus.o_combo     <= '0;
          bus.o_max_combo <= '0;
        end
        S_PLAY: if (bus.i_restart || bus.i_song_end) begin
          state            <= bus.i_restart ? S_IDLE : S_RESULT;
          bus.o_run        <= 1'b0;
          bus.o_judge_hold <= J_NONE;
          hcnt             <= '0;
        end
        S_RESULT: if (bus.i_restart) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
